// File: rtl/in_flight_tracker_pooled_if.sv
// Issuer-side bus of the pooled in-flight tracker: push/pop requests, per-colour
// ready, count readback and sticky error flags.
interface in_flight_tracker_pooled_if #(
    parameter int COLORS    = 4,
    parameter int MAX_DEPTH = 512
);
    localparam int TW = $clog2(COLORS);
    localparam int CW = $clog2(MAX_DEPTH) + 1;

    // A push takes effect only in a cycle where push=1 and ready[push_tag]=1;
    // ready is a registered-state function and never looks at same-cycle push/pop.
    logic              push;
    logic [TW-1:0]     push_tag;
    logic              pop;
    logic [TW-1:0]     pop_tag;
    logic [COLORS-1:0] ready;
    logic [TW-1:0]     read_tag;
    logic [CW-1:0]     count;
    logic [CW-1:0]     total;
    logic              err_overflow;
    logic              err_underflow;
    logic              err_clear;

    modport master (
        output push, push_tag, pop, pop_tag, read_tag, err_clear,
        input  ready, count, total, err_overflow, err_underflow
    );

    modport slave (
        input  push, push_tag, pop, pop_tag, read_tag, err_clear,
        output ready, count, total, err_overflow, err_underflow
    );
endinterface

// File: rtl/in_flight_tracker_pooled.sv
// Per-colour outstanding-request tracker: each colour owns MIN_DEPTH reserved
// slots and all colours share a HEAD_ROOM pool tracked incrementally.
module in_flight_tracker_pooled #(
    parameter int COLORS    = 4,
    parameter int MIN_DEPTH = 32,
    parameter int MAX_DEPTH = 512,
    parameter int COLOR_CAP = 512
) (
    input  logic                      clk,
    input  logic                      rst_n,
    in_flight_tracker_pooled_if.slave bus
);
    localparam int CW        = $clog2(MAX_DEPTH) + 1;
    localparam int HEAD_ROOM = MAX_DEPTH - COLORS * MIN_DEPTH;
    localparam int CAP_EFF   = (COLOR_CAP < MIN_DEPTH + HEAD_ROOM) ? COLOR_CAP
                                                                   : MIN_DEPTH + HEAD_ROOM;
    localparam logic [CW-1:0] MIN_V  = CW'(MIN_DEPTH);
    localparam logic [CW-1:0] HEAD_V = CW'(HEAD_ROOM);
    localparam logic [CW-1:0] CAP_V  = CW'(CAP_EFF);
    localparam logic [CW-1:0] MAX_V  = CW'(MAX_DEPTH);

    if (COLORS < 2 || (COLORS & (COLORS - 1)) != 0) begin : g_bad_colors
        $error("COLORS must be a power of two, at least 2");
    end
    if (MAX_DEPTH < COLORS * MIN_DEPTH) begin : g_bad_depth
        $error("MAX_DEPTH must be at least COLORS*MIN_DEPTH");
    end

    logic [CW-1:0]     cnt     [COLORS];
    logic [CW-1:0]     cnt_nxt [COLORS];
    logic [CW-1:0]     shared_used, shared_nxt;
    logic [CW-1:0]     total_q, total_nxt;
    logic [CW-1:0]     count_q;
    logic [COLORS-1:0] ready;
    logic              err_ov_q, err_un_q;
    logic              push_ok, pop_ok, same_tag_pair, push_eff, pop_eff;
    logic              push_into_shared, pop_from_shared;

    always_comb begin
        ready = '0;
        for (int c = 0; c < COLORS; c++) begin
            ready[c] = (cnt[c] < MIN_V) || ((shared_used < HEAD_V) && (cnt[c] < CAP_V));
        end
    end

    assign push_ok       = bus.push && ready[bus.push_tag];
    assign pop_ok        = bus.pop && (cnt[bus.pop_tag] != '0);
    // An accepted push and pop on one colour cancel; neither touches the pool.
    assign same_tag_pair = push_ok && pop_ok && (bus.push_tag == bus.pop_tag);
    assign push_eff      = push_ok && !same_tag_pair;
    assign pop_eff       = pop_ok && !same_tag_pair;
    assign push_into_shared = push_eff && (cnt[bus.push_tag] >= MIN_V);
    assign pop_from_shared  = pop_eff && (cnt[bus.pop_tag] > MIN_V);

    always_comb begin
        for (int c = 0; c < COLORS; c++) begin
            cnt_nxt[c] = cnt[c];
        end
        if (push_eff) cnt_nxt[bus.push_tag] = cnt[bus.push_tag] + 1'b1;
        if (pop_eff)  cnt_nxt[bus.pop_tag]  = cnt[bus.pop_tag] - 1'b1;
        shared_nxt = shared_used + CW'(push_into_shared) - CW'(pop_from_shared);
        total_nxt  = total_q + CW'(push_eff) - CW'(pop_eff);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < COLORS; c++) begin
                cnt[c] <= '0;
            end
            shared_used <= '0;
            total_q     <= '0;
            count_q     <= '0;
            err_ov_q    <= 1'b0;
            err_un_q    <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            shared_used <= shared_nxt;
            total_q     <= total_nxt;
            count_q     <= cnt_nxt[bus.read_tag];
            // A new error wins over a clear in the same cycle.
            if (bus.push && !ready[bus.push_tag]) err_ov_q <= 1'b1;
            else if (bus.err_clear)               err_ov_q <= 1'b0;
            if (bus.pop && !pop_ok)               err_un_q <= 1'b1;
            else if (bus.err_clear)               err_un_q <= 1'b0;
        end
    end

    assign bus.ready         = ready;
    assign bus.count         = count_q;
    assign bus.total         = total_q;
    assign bus.err_overflow  = err_ov_q;
    assign bus.err_underflow = err_un_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            assert (total_q <= MAX_V);
            assert (shared_used <= HEAD_V);
            for (int c = 0; c < COLORS; c++) begin
                assert (cnt[c] <= CAP_V);
            end
        end
    end
`endif
endmodule

// File: doc/in_flight_tracker_pooled.md
Name: in_flight_tracker_pooled

Overview:
Parametrised next-generation in-flight request tracker. Keeps a per-colour (tag) outstanding count. Each colour owns a guaranteed reservation of MIN_DEPTH slots, and all colours share a HEAD_ROOM pool of MAX_DEPTH - COLORS*MIN_DEPTH slots. Sits between the request issuers and the decoder memory interface. Adds over the single-ready tracker: a per-colour ready vector, a per-colour cap, a registered count readback, a total count, and sticky protocol-error flags.

Parameters:
COLORS, 4, number of tags; power of two, at least 2
MIN_DEPTH, 32, slots reserved per colour
MAX_DEPTH, 512, total slots; must be at least COLORS*MIN_DEPTH (elaboration error otherwise)
COLOR_CAP, 512, hard per-colour ceiling; clamped to MIN_DEPTH + HEAD_ROOM

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
push  in  1  issue request for push_tag
push_tag  in  log2(COLORS)  tag of pushed request
pop  in  1  completion of a request for pop_tag
pop_tag  in  log2(COLORS)  tag of completed request
ready  out  COLORS  ready[c] = colour c may accept a push this cycle
read_tag  in  log2(COLORS)  colour selected for count readback
count  out  log2(MAX_DEPTH)+1  registered count of read_tag
total  out  log2(MAX_DEPTH)+1  sum of all colour counts
err_overflow  out  1  sticky: push while ready[push_tag]=0
err_underflow  out  1  sticky: pop while count of pop_tag = 0
err_clear  in  1  synchronous clear of both error flags

Behaviour:
- State: cnt[c] for each colour, width log2(MAX_DEPTH)+1, plus shared_used register.
- shared_used = sum over c of max(cnt[c]-MIN_DEPTH, 0). Maintained incrementally; never recomputed with an adder tree.
- ready[c] is combinational from registered state only; it never depends on the same-cycle push or pop:
  - if cnt[c] < MIN_DEPTH, ready[c] = 1;
  - else ready[c] = (shared_used < HEAD_ROOM) and (cnt[c] < COLOR_CAP).
- Push is accepted when push and ready[push_tag]: cnt +1 at the clock edge. If cnt was at least MIN_DEPTH before the push, shared_used also +1.
- Push with ready[push_tag]=0: dropped, no state change, err_overflow set next cycle.
- Pop is accepted when pop and cnt[pop_tag] > 0: cnt -1. If cnt was above MIN_DEPTH before the pop, shared_used also -1.
- Pop with cnt[pop_tag]=0: ignored, err_underflow set next cycle.
- Push and pop, same tag, both accepted: cnt and shared_used unchanged.
- Push and pop, same tag, push rejected: only the pop applies. A same-cycle pop does not rescue a push.
- Push and pop, different tags: both apply independently, and shared_used nets the two deltas (-1..+1).
- total: registered. Updates with net delta -1/0/+1 each cycle. Always equals the sum of cnt.
- count: registered, 1-cycle latency. Cycle N+1 shows cnt[read_tag of cycle N] after cycle N's updates.
- err flags: set has priority over err_clear in the same cycle.
- Reset (async assert, synchronous release): all cnt, shared_used, total and count = 0; err flags = 0; ready = all ones. Reset mid-traffic discards all in-flight state, and pops after reset are underflows.
- Invariants: total <= MAX_DEPTH; shared_used <= HEAD_ROOM; cnt[c] <= min(COLOR_CAP, MIN_DEPTH+HEAD_ROOM). Assertions are included under a simulation-only guard.

Test Plan:
- Default parameters, push colour 0 every cycle until ready[0]=0 -> 416 accepted; shared_used=384; ready[1..3]=1; total=416.
- Then push colour 1 until ready[1]=0 -> 32 accepted (reservation only); total=448; count for read_tag=1 reads 32 one cycle later.
- One pop colour 0 -> next cycle ready[1]=1; one push colour 1 accepted (33); ready[1]=0 again.
- Push and pop colour 0 in the same cycle at cnt=416 (ready=0) -> push dropped, cnt=415, err_overflow=1; err_clear alone -> err_overflow=0 next cycle.
- Pop colour 2 at cnt=0 -> err_underflow=1, counts unchanged. Then COLOR_CAP=40 build: push colour 3 -> stops at 40 while shared_used=8.
- Assert rst_n low mid-stream, asynchronously between edges -> all counts and flags 0 immediately; ready=4'b1111.
